// File: rtl/dmem_port_if.sv
// Core-side request/response bundle for the data-memory access stage.
// Handshake: a request is taken on the rising edge where req_valid && req_ready; the
// fields are sampled only at that edge. rsp_valid is a single-cycle completion pulse.
interface dmem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_port.sv
// Load/store access stage: word-aligned accesses to a 4-lane big-endian memory with
// fixed read latency, read-modify-write for sub-word stores, load extension, misalign flag.
module dmem_port #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            halted,
  dmem_port_if.slave      req,
  output logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_out,
  output logic [0:3][7:0] mem_data_in,
  output logic            mem_write_en,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic            we_q, signed_q, err_q;
  logic [1:0]      size_q;
  logic [31:0]     addr_q, wdata_q;
  logic [0:3][7:0] word_q;
  logic [0:3][7:0] merged;
  logic [31:0]     load_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            accept, req_err;

  assign accept    = req.req_valid && req.req_ready;
  assign state_dbg = state_q;

  always_comb begin
    req_err = 1'b0;
    case (req.req_size)
      2'd1:    req_err = req.req_addr[0];
      2'd2:    req_err = |req.req_addr[1:0];
      2'd3:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (req_err)                                state_d = DONE;
        else if (req.req_we && req.req_size == 2'd2) state_d = WR;
        else                                        state_d = RD;
      end
      RD:      if (cnt_q == 4'd0) state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      word_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req.req_we;
        signed_q <= req.req_signed;
        err_q    <= req_err;
        size_q   <= req.req_size;
        addr_q   <= req.req_addr;
        wdata_q  <= req.req_wdata;
        cnt_q    <= CNT_INIT;
      end else if (state_q == RD) begin
        // The closing edge of the last RD cycle is where read data is valid.
        if (cnt_q == 4'd0) word_q <= mem_data_out;
        else               cnt_q  <= cnt_q - 4'd1;
      end
    end
  end

  // Lane 0 is the most significant byte; a half occupies lanes {a1,0} (upper) and {a1,1}.
  always_comb begin
    merged = word_q;
    case (size_q)
      2'd0: merged[addr_q[1:0]] = wdata_q[7:0];
      2'd1: begin
        merged[{addr_q[1], 1'b0}] = wdata_q[15:8];
        merged[{addr_q[1], 1'b1}] = wdata_q[7:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    ld_byte   = word_q[addr_q[1:0]];
    ld_half   = {word_q[{addr_q[1], 1'b0}], word_q[{addr_q[1], 1'b1}]};
    load_data = word_q;
    case (size_q)
      2'd0:    load_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    load_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: load_data = word_q;
    endcase
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    req.req_ready = (state_q == IDLE) && !halted;
    req.rsp_valid = (state_q == DONE);
    req.rsp_err   = (state_q == DONE) && err_q;
    req.rsp_rdata = ((state_q == DONE) && !we_q && !err_q) ? load_data : 32'd0;
    mem_addr      = (state_q == RD || state_q == WR) ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_write_en  = (state_q == WR);
    mem_data_in   = (state_q == WR) ? merged : '0;
  end

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: a MEM_LATENCY=1 and a MEM_LATENCY=4 instance, each with
// its own behavioural memory, driven from a shared request driver.
module tb_dmem_port;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic halted = 1'b0;
  logic preload = 1'b1;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic        d_valid = 1'b0, d_we = 1'b0, d_signed = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;

  dmem_port_if if1();
  dmem_port_if if4();

  assign if1.req_valid = d_valid && !sel;
  assign if4.req_valid = d_valid && sel;
  assign if1.req_we = d_we;         assign if4.req_we = d_we;
  assign if1.req_size = d_size;     assign if4.req_size = d_size;
  assign if1.req_signed = d_signed; assign if4.req_signed = d_signed;
  assign if1.req_addr = d_addr;     assign if4.req_addr = d_addr;
  assign if1.req_wdata = d_wdata;   assign if4.req_wdata = d_wdata;

  logic [31:0] a1, a4, din1, din4, dout1, dout4;
  logic        we1, we4;
  logic [1:0]  st1, st4;

  dmem_port #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .halted(halted), .req(if1),
    .mem_addr(a1), .mem_data_out(dout1), .mem_data_in(din1),
    .mem_write_en(we1), .state_dbg(st1)
  );

  dmem_port #(.MEM_LATENCY(4)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .halted(halted), .req(if4),
    .mem_addr(a4), .mem_data_out(dout4), .mem_data_in(din4),
    .mem_write_en(we4), .state_dbg(st4)
  );

  // Behavioural memories: combinational read for latency 1, three extra stages for latency 4.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem4 [0:255];
  logic [31:0] p0, p1, p2;

  assign dout1 = mem1[a1[9:2]];
  assign dout4 = p2;

  always @(posedge clk) begin
    if (preload) begin
      mem1[8'h40] <= 32'h8A3CF00D;
      mem4[8'hC0] <= 32'h11223344;
    end else begin
      if (we1) mem1[a1[9:2]] <= din1;
      if (we4) mem4[a4[9:2]] <= din4;
    end
    p0 <= mem4[a4[9:2]];
    p1 <= p0;
    p2 <= p1;
  end

  logic        m_ready, m_rsp, m_err, m_we;
  logic [31:0] m_rdata, m_addr, m_din;
  logic [1:0]  m_state;
  assign m_ready = sel ? if4.req_ready : if1.req_ready;
  assign m_rsp   = sel ? if4.rsp_valid : if1.rsp_valid;
  assign m_err   = sel ? if4.rsp_err   : if1.rsp_err;
  assign m_rdata = sel ? if4.rsp_rdata : if1.rsp_rdata;
  assign m_we    = sel ? we4  : we1;
  assign m_addr  = sel ? a4   : a1;
  assign m_din   = sel ? din4 : din1;
  assign m_state = sel ? st4  : st1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_din;
    logic        exp_err;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic [31:0] exp_din,
                              input logic exp_err, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_din = exp_din; v.exp_err = exp_err; v.lat = lat;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    d_we = v.we; d_size = v.size; d_signed = v.sgn; d_addr = v.addr; d_wdata = v.wdata;
    d_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the request inputs so any late sampling of them is exposed.
    d_valid = 1'b0;
    d_we = 1'($urandom_range(0, 1));
    d_size = 2'($urandom_range(0, 3));
    d_signed = 1'($urandom_range(0, 1));
    d_addr = $urandom;
    d_wdata = $urandom;
  endtask

  task automatic run_txn(input vec_t v);
    int k;
    bit seen;
    int wcnt, rdy_bad, addr_bad;
    k = 0;
    while (!m_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_before", {31'd0, m_ready}, 32'd1);
    drive_req(v);
    exp_q.push_back(v.exp_rdata);
    seen = 1'b0; wcnt = 0; rdy_bad = 0; addr_bad = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (m_ready) rdy_bad++;
      if (v.exp_err && m_addr != 32'd0) addr_bad++;
      if (m_we) begin
        wcnt++;
        check("wr_data", m_din, v.exp_din);
        check("wr_addr", m_addr, {v.addr[31:2], 2'b00});
      end
      if (m_rsp) begin
        seen = 1'b1;
        check("latency", 32'(c), 32'(v.lat));
        check("rdata", m_rdata, exp_q.pop_front());
        check("err", {31'd0, m_err}, {31'd0, v.exp_err});
      end
    end
    check("rsp_seen", {31'd0, seen}, 32'd1);
    if (!seen) exp_q.delete();
    check("wr_count", 32'(wcnt), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
    check("ready_low_busy", 32'(rdy_bad), 32'd0);
    check("err_addr_zero", 32'(addr_bad), 32'd0);
    @(negedge clk);
    check("rsp_one_cycle", {31'd0, m_rsp}, 32'd0);
    check("idle_after", {30'd0, m_state}, 32'd0);
  endtask

  vec_t vecs1[16];
  vec_t vecs4[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int bad;
    bit seen;

    //      we    size  sgn   addr          wdata         rdata         din           err   lat
    vecs1[0]  = mk(1'b0, 2'd0, 1'b1, 32'h100, 32'h0,        32'hFFFFFF8A, 32'h0,        1'b0, 2);
    vecs1[1]  = mk(1'b0, 2'd0, 1'b0, 32'h100, 32'h0,        32'h0000008A, 32'h0,        1'b0, 2);
    vecs1[2]  = mk(1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        32'h0000003C, 32'h0,        1'b0, 2);
    vecs1[3]  = mk(1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'hFFFFF00D, 32'h0,        1'b0, 2);
    vecs1[4]  = mk(1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'h0000F00D, 32'h0,        1'b0, 2);
    vecs1[5]  = mk(1'b1, 2'd1, 1'b0, 32'h100, 32'hAAAA1234, 32'h0,        32'h1234F00D, 1'b0, 3);
    vecs1[6]  = mk(1'b0, 2'd2, 1'b1, 32'h100, 32'h0,        32'h1234F00D, 32'h0,        1'b0, 2);
    vecs1[7]  = mk(1'b1, 2'd0, 1'b0, 32'h103, 32'h00000077, 32'h0,        32'h1234F077, 1'b0, 3);
    vecs1[8]  = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h1234F077, 32'h0,        1'b0, 2);
    vecs1[9]  = mk(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    vecs1[10] = mk(1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 2);
    vecs1[11] = mk(1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        32'h0,        32'h0,        1'b1, 1);
    vecs1[12] = mk(1'b0, 2'd1, 1'b1, 32'h101, 32'h0,        32'h0,        32'h0,        1'b1, 1);
    vecs1[13] = mk(1'b0, 2'd3, 1'b0, 32'h104, 32'h0,        32'h0,        32'h0,        1'b1, 1);
    vecs1[14] = mk(1'b1, 2'd2, 1'b0, 32'h202, 32'h01020304, 32'h0,        32'h0,        1'b1, 1);
    vecs1[15] = mk(1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 2);

    vecs4[0] = mk(1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        32'h11223344, 32'h0,        1'b0, 5);
    vecs4[1] = mk(1'b0, 2'd0, 1'b1, 32'h302, 32'h0,        32'h00000033, 32'h0,        1'b0, 5);
    vecs4[2] = mk(1'b0, 2'd1, 1'b1, 32'h300, 32'h0,        32'h00001122, 32'h0,        1'b0, 5);
    vecs4[3] = mk(1'b1, 2'd0, 1'b0, 32'h301, 32'h000000FF, 32'h0,        32'h11FF3344, 1'b0, 6);
    vecs4[4] = mk(1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        32'h11FF3344, 32'h0,        1'b0, 5);
    vecs4[5] = mk(1'b0, 2'd0, 1'b1, 32'h301, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 5);

    // Clock/reset: hold reset while the memories are preloaded.
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_ready", {31'd0, m_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, m_rsp}, 32'd0);
      check("rst_mem_we", {31'd0, m_we}, 32'd0);
      check("rst_mem_addr", m_addr, 32'd0);
      check("rst_mem_din", m_din, 32'd0);
      check("rst_state", {30'd0, m_state}, 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_txn(vecs1[i]);

    // Reset during the WR cycle of a halfword store.
    drive_req(mk(1'b1, 2'd1, 1'b0, 32'h100, 32'h5555ABCD, 32'h0, 32'h0, 1'b0, 3));
    k = 0;
    while (!m_we && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rstwr_in_wr", {31'd0, m_we}, 32'd1);
    check("rstwr_merge", m_din, 32'hABCDF077);
    #1 rst_b = 1'b0;
    #1;
    check("rstwr_we_drop", {31'd0, m_we}, 32'd0);
    check("rstwr_state", {30'd0, m_state}, 32'd0);
    check("rstwr_addr", m_addr, 32'd0);
    check("rstwr_din", m_din, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_rsp) bad++;
    end
    check("rstwr_no_rsp", 32'(bad), 32'd0);
    run_txn(mk(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 32'h00000012, 32'h0, 1'b0, 2));
    run_txn(mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h1234F077, 32'h0, 1'b0, 2));

    // Latency-4 instance.
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_txn(vecs4[i]);

    // Halted with a request held: nothing is accepted.
    halted = 1'b1;
    d_we = 1'b0; d_size = 2'd2; d_addr = 32'h300; d_valid = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_ready || m_state != 2'd0) bad++;
    end
    check("halt_blocks", 32'(bad), 32'd0);
    d_valid = 1'b0;
    halted = 1'b0;
    @(negedge clk);

    // Halt raised mid-access: the in-flight load still completes.
    drive_req(mk(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0, 5));
    halted = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (m_rsp) begin
        seen = 1'b1;
        check("halt_mid_lat", 32'(c), 32'd5);
        check("halt_mid_rdata", m_rdata, 32'h11FF3344);
      end
    end
    check("halt_mid_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("halt_mid_ready", {31'd0, m_ready}, 32'd0);
    halted = 1'b0;
    #1;
    check("unhalt_ready", {31'd0, m_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
